// File: rtl/mcu_pkg.sv
// Shared definitions for the microcontroller: opcodes, dispatcher state
// encoding and the default opcode-ownership mask.
package mcu_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALUI_A = 4'h1;
  localparam logic [3:0] OP_ALUI_B = 4'h2;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [15:0] EXEC_MASK_DEFAULT = 16'h0006;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    CLEAR,
    HALT
  } disp_state_t;

  function automatic logic has_exec_fsm(input logic [15:0] mask, input logic [3:0] op);
    return mask[op];
  endfunction

endpackage

// File: rtl/exec_watchdog.sv
// EXEC-state timeout counter; expired flags the cycle in which the
// TIMEOUT-th consecutive enabled cycle elapses.
module exec_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT))) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_dispatch.sv
// Instruction fetch/dispatch sequencer: fetches, broadcasts the instruction
// to the execution FSMs, tracks the PC and clears the bus after completion.
module instr_dispatch
  import mcu_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [15:0] EXEC_MASK = EXEC_MASK_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [15:0]     mem_data,
  input  logic            mem_valid,
  output logic [15:0]     fullBitNum,
  input  logic            PC_inc,
  input  logic            done,
  output logic            busy,
  output logic            halted,
  output logic            fault
);

  disp_state_t     state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [15:0]     ir, ir_nxt;
  logic            halted_nxt, fault_nxt;
  logic            wd_expired;
  logic [3:0]      opcode;

  assign opcode     = mem_data[15:12];
  assign mem_addr   = pc;
  assign fullBitNum = ir;

  exec_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != EXEC),
    .enable (state == EXEC),
    .expired(wd_expired)
  );

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    halted_nxt = halted;
    fault_nxt  = fault;
    case (state)
      IDLE: begin
        ir_nxt = '0;
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        if (mem_valid) begin
          if (opcode == OP_NOP) begin
            pc_nxt    = pc + PC_W'(1);
            ir_nxt    = '0;
            state_nxt = CLEAR;
          end else if (opcode == OP_HALT) begin
            halted_nxt = 1'b1;
            state_nxt  = HALT;
          end else if (has_exec_fsm(EXEC_MASK, opcode)) begin
            ir_nxt    = mem_data;
            state_nxt = EXEC;
          end else begin
            fault_nxt  = 1'b1;
            halted_nxt = 1'b1;
            state_nxt  = HALT;
          end
        end
      end
      EXEC: begin
        if (PC_inc) pc_nxt = pc + PC_W'(1);
        // done has priority over a coincident watchdog expiry
        if (done) begin
          ir_nxt    = '0;
          state_nxt = CLEAR;
        end else if (wd_expired) begin
          ir_nxt     = '0;
          fault_nxt  = 1'b1;
          halted_nxt = 1'b1;
          state_nxt  = HALT;
        end
      end
      CLEAR: begin
        ir_nxt    = '0;
        state_nxt = run ? FETCH : IDLE;
      end
      HALT: begin
        ir_nxt = '0;
      end
      default: begin
        ir_nxt    = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake/status outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= '0;
      ir     <= '0;
      mem_rd <= 1'b0;
      busy   <= 1'b0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      ir     <= ir_nxt;
      mem_rd <= (state_nxt == FETCH);
      busy   <= (state_nxt == FETCH) || (state_nxt == EXEC) || (state_nxt == CLEAR);
      halted <= halted_nxt;
      fault  <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch with a single-cycle memory model and a
// scripted execution-FSM model driving PC_inc/done.
module tb_instr_dispatch;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            run = 1'b0;
  logic [PC_W-1:0] mem_addr;
  logic            mem_rd;
  logic [15:0]     mem_data = '0;
  logic            mem_valid = 1'b0;
  logic [15:0]     fullBitNum;
  logic            PC_inc = 1'b0;
  logic            done = 1'b0;
  logic            busy, halted, fault;

  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          exec_cnt = 0;
  int          inc_at = 0;
  int          done_at = 0;
  logic        rd_seen = 1'b0;
  logic        force_inc = 1'b0;
  logic        force_done = 1'b0;

  instr_dispatch #(
    .PC_W     (PC_W),
    .TIMEOUT  (15),
    .EXEC_MASK(16'h0006)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .fullBitNum(fullBitNum),
    .PC_inc    (PC_inc),
    .done      (done),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Advance one cycle, then update memory and execution-FSM models.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_valid) begin
      mem_valid = 1'b0;
      rd_seen   = 1'b0;
    end else if (mem_rd && rd_seen) begin
      mem_valid = 1'b1;
      mem_data  = mem[mem_addr];
    end else begin
      rd_seen = mem_rd;
    end
    if (fullBitNum != 16'h0) exec_cnt++;
    else exec_cnt = 0;
    PC_inc = force_inc || (inc_at != 0 && exec_cnt == inc_at);
    done   = force_done || (done_at != 0 && exec_cnt == done_at);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    inc_at = 0;
    done_at = 0;
    force_inc = 1'b0;
    force_done = 1'b0;
    tick();
    tick();
    mem_valid = 1'b0;
    rd_seen = 1'b0;
    exec_cnt = 0;
    PC_inc = 1'b0;
    done = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({fullBitNum, mem_rd, busy, halted, fault} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ir=%h rd=%b busy=%b halted=%b fault=%b expected all 0",
               fullBitNum, mem_rd, busy, halted, fault);
    end
    checks++;
    if (mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_pc: got %h expected 00", mem_addr);
    end
    do_reset();
  endtask

  task automatic test_alui();
    int n;
    do_reset();
    mem[0] = 16'h1085;
    mem[1] = 16'hF000;
    inc_at = 2;
    done_at = 9;
    run = 1'b1;
    n = 0;
    while (fullBitNum == 16'h0 && n < 10) begin tick(); n++; end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL alui_ir_latency: got %0d cycles expected 3", n);
    end
    n = 0;
    while (fullBitNum == 16'h1085 && n < 30) begin tick(); n++; end
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL alui_ir_hold: got %0d cycles expected 9", n);
    end
    checks++;
    if ({fullBitNum, busy, mem_rd} !== {16'h0, 1'b1, 1'b0} || mem_addr !== 8'h01) begin
      errors++;
      $display("FAIL alui_clear: got ir=%h busy=%b rd=%b pc=%h expected ir=0 busy=1 rd=0 pc=01",
               fullBitNum, busy, mem_rd, mem_addr);
    end
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h01 || fault !== 1'b0) begin
      errors++;
      $display("FAIL alui_next_fetch: got rd=%b addr=%h fault=%b expected rd=1 addr=01 fault=0",
               mem_rd, mem_addr, fault);
    end
  endtask

  task automatic test_nop_halt();
    logic rd_again;
    do_reset();
    mem[0] = 16'h0000;
    mem[1] = 16'h0000;
    mem[2] = 16'hF000;
    run = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 3) begin
        checks++;
        if (mem_addr !== 8'h01 || busy !== 1'b1 || mem_rd !== 1'b0) begin
          errors++;
          $display("FAIL nop_pc_step: got pc=%h busy=%b rd=%b expected pc=01 busy=1 rd=0",
                   mem_addr, busy, mem_rd);
        end
      end
      if (i == 8) begin
        checks++;
        if (halted !== 1'b0) begin
          errors++;
          $display("FAIL nop_early_halt: got halted=%b expected 0", halted);
        end
      end
    end
    checks++;
    if ({halted, busy, mem_rd, fault} !== 4'b1000 || mem_addr !== 8'h02) begin
      errors++;
      $display("FAIL halt_state: got halted=%b busy=%b rd=%b fault=%b pc=%h expected 1 0 0 0 pc=02",
               halted, busy, mem_rd, fault, mem_addr);
    end
    rd_again = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_rd) rd_again = 1'b1;
    end
    checks++;
    if (rd_again !== 1'b0 || fullBitNum !== 16'h0) begin
      errors++;
      $display("FAIL halt_terminal: got rd_seen=%b ir=%h expected 0 0", rd_again, fullBitNum);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    mem[0] = 16'h5000;
    run = 1'b1;
    tick();
    tick();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL illegal_early: got fault=%b expected 0", fault);
    end
    tick();
    checks++;
    if ({fault, halted, busy, mem_rd} !== 4'b1100 || fullBitNum !== 16'h0 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL illegal_fault: got fault=%b halted=%b busy=%b rd=%b ir=%h pc=%h expected 1 1 0 0 ir=0 pc=00",
               fault, halted, busy, mem_rd, fullBitNum, mem_addr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem[0] = 16'h1085;
    run = 1'b1;
    for (int i = 1; i <= 17; i++) tick();
    checks++;
    if (fault !== 1'b0 || fullBitNum !== 16'h1085) begin
      errors++;
      $display("FAIL timeout_before: got fault=%b ir=%h expected 0 1085", fault, fullBitNum);
    end
    tick();
    checks++;
    if ({fault, halted, busy} !== 3'b110 || fullBitNum !== 16'h0) begin
      errors++;
      $display("FAIL timeout_fault: got fault=%b halted=%b busy=%b ir=%h expected 1 1 0 ir=0",
               fault, halted, busy, fullBitNum);
    end
    do_reset();
    mem[0] = 16'h1085;
    done_at = 15;
    run = 1'b1;
    for (int i = 1; i <= 18; i++) tick();
    checks++;
    if ({fault, halted, busy} !== 3'b001 || fullBitNum !== 16'h0) begin
      errors++;
      $display("FAIL timeout_done_wins: got fault=%b halted=%b busy=%b ir=%h expected 0 0 1 ir=0",
               fault, halted, busy, fullBitNum);
    end
  endtask

  task automatic test_pc_wrap();
    int n;
    do_reset();
    run = 1'b1;
    n = 0;
    while (mem_addr != 8'hFF && n < 1000) begin tick(); n++; end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL wrap_reach_ff: got pc=%h after %0d cycles expected ff", mem_addr, n);
    end
    tick();
    run = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_addr !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pc: got pc=%h busy=%b expected 00 1", mem_addr, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL wrap_park_idle: got busy=%b rd=%b expected 0 0", busy, mem_rd);
    end
    run = 1'b1;
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_next_fetch: got rd=%b addr=%h expected 1 00", mem_rd, mem_addr);
    end
  endtask

  task automatic test_rst_mid_exec();
    do_reset();
    mem[0] = 16'h2041;
    inc_at = 2;
    run = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (fullBitNum !== 16'h2041) begin
      errors++;
      $display("FAIL rst_exec_ir: got %h expected 2041", fullBitNum);
    end
    tick();
    tick();
    checks++;
    if (mem_addr !== 8'h01) begin
      errors++;
      $display("FAIL rst_exec_pc_inc: got %h expected 01", mem_addr);
    end
    rst = 1'b1;
    run = 1'b0;
    tick();
    checks++;
    if ({fullBitNum, mem_rd, busy, halted, fault} !== 20'h0 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL rst_exec_outputs: got ir=%h rd=%b busy=%b halted=%b fault=%b pc=%h expected all 0",
               fullBitNum, mem_rd, busy, halted, fault, mem_addr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL rst_exec_idle: got busy=%b rd=%b expected 0 0", busy, mem_rd);
    end
  endtask

  task automatic test_run_drop();
    do_reset();
    mem[0] = 16'h1085;
    inc_at = 2;
    done_at = 9;
    run = 1'b1;
    tick();
    tick();
    tick();
    run = 1'b0;
    for (int i = 4; i <= 12; i++) tick();
    checks++;
    if (busy !== 1'b1 || fullBitNum !== 16'h0 || mem_addr !== 8'h01) begin
      errors++;
      $display("FAIL run_drop_clear: got busy=%b ir=%h pc=%h expected 1 0 01", busy, fullBitNum, mem_addr);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL run_drop_idle: got busy=%b rd=%b expected 0 0", busy, mem_rd);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    mem[0] = 16'h1085;
    mem[1] = 16'h2041;
    mem[2] = 16'hF000;
    inc_at = 9;
    done_at = 9;
    run = 1'b1;
    for (int i = 1; i <= 12; i++) tick();
    checks++;
    if (mem_addr !== 8'h01 || fullBitNum !== 16'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_inc_with_done: got pc=%h ir=%h busy=%b expected 01 0 1", mem_addr, fullBitNum, busy);
    end
    for (int i = 1; i <= 3; i++) tick();
    checks++;
    if (fullBitNum !== 16'h2041) begin
      errors++;
      $display("FAIL b2b_second_ir: got %h expected 2041", fullBitNum);
    end
    n = 0;
    while (!halted && n < 40) begin tick(); n++; end
    checks++;
    if (halted !== 1'b1 || fault !== 1'b0 || mem_addr !== 8'h02) begin
      errors++;
      $display("FAIL b2b_halt: got halted=%b fault=%b pc=%h expected 1 0 02", halted, fault, mem_addr);
    end
  endtask

  task automatic test_ignored_inputs();
    do_reset();
    force_inc = 1'b1;
    force_done = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (mem_addr !== 8'h00 || busy !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL ignored_idle: got pc=%h busy=%b fault=%b expected 00 0 0", mem_addr, busy, fault);
    end
    force_inc = 1'b0;
    force_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alui();
    test_nop_halt();
    test_illegal();
    test_timeout();
    test_pc_wrap();
    test_rst_mid_exec();
    test_run_drop();
    test_back_to_back();
    test_ignored_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_dispatch.md
# instr_dispatch

Instruction fetch/dispatch sequencer that initiates every execution FSM in the microcontroller. It fetches a 16-bit instruction word from program memory, presents it on `fullBitNum` so the matching opcode-selected execution FSM (ALUI and peers) runs, and advances the PC on that FSM's `PC_inc` pulse. It waits for `done`, then forces the instruction bus to NOP so every execution FSM returns to its idle state. NOP, HALT, illegal opcodes and execution timeouts are handled locally.

## Interface
- `PC_W`, 8, program counter / memory address width
- `TIMEOUT`, 15, max cycles in EXEC without `done` before fault (≥ 10)
- `EXEC_MASK`, 16'h0006, bit n set = opcode n has an execution FSM
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `run`  in  1  level; permits fetching
- `mem_addr`  out  PC_W  fetch address (= PC)
- `mem_rd`  out  1  fetch request, held until `mem_valid`
- `mem_data`  in  16  instruction word, valid with `mem_valid`
- `mem_valid`  in  1  fetch response strobe
- `fullBitNum`  out  16  instruction register broadcast to execution FSMs
- `PC_inc`  in  1  OR of execution-FSM PC increment requests
- `done`  in  1  OR of execution-FSM done pulses
- `busy`  out  1  high in FETCH, EXEC, CLEAR
- `halted`  out  1  sticky; HALT state reached
- `fault`  out  1  sticky; illegal opcode or timeout

## Operation
- States: IDLE, FETCH, EXEC, CLEAR, HALT.
- IDLE: `fullBitNum`=0. `run`=1 → FETCH.
- FETCH: `mem_rd`=1. On `mem_valid`, decode `mem_data[15:12]`:
  - 4'h0 (NOP): PC+1, IR stays 0, → CLEAR.
  - 4'hF (HALT): PC unchanged, `halted`=1, → HALT.
  - opcode with `EXEC_MASK` bit set: IR ← `mem_data`, watchdog cleared, → EXEC.
  - otherwise: `fault`=1, → HALT.
- EXEC: IR held stable. Each cycle `PC_inc`=1 → PC+1. `done`=1 → IR ← 0, → CLEAR. Watchdog reaches `TIMEOUT` without `done` → IR ← 0, `fault`=1, → HALT.
- CLEAR: IR=0 for exactly one cycle (execution FSMs see the non-owned opcode and return to idle). `run`=1 → FETCH, else → IDLE.
- HALT: terminal; `fullBitNum`=0, `mem_rd`=0. Only `rst` exits.
- PC arithmetic is modulo 2^PC_W (wraps from all-ones to 0).
- Watchdog width is $clog2(TIMEOUT+1). It counts only in EXEC.

## Timing
- Reset values: PC=0, `fullBitNum`=0, `mem_rd`=0, `busy`=0, `halted`=0, `fault`=0, state IDLE.
- All outputs are registered.
- `mem_rd` asserts the cycle after entering FETCH and deasserts the cycle after `mem_valid` is sampled. `mem_addr` is stable while `mem_rd`=1.
- IR is visible the cycle after `mem_valid`. An ALUI op (8 FSM states to done) yields `done` sampled 9 cycles after IR load. Fetch-to-fetch minimum for ALUI is 12 cycles with single-cycle memory.
- NOP: `mem_valid` → CLEAR → FETCH; 3 cycles per NOP with single-cycle memory.
- Simultaneous events:
  - `done` together with watchdog expiry: `done` wins, no fault.
  - `PC_inc` together with `done`: both honoured.
- Ignored inputs:
  - `mem_valid` outside FETCH.
  - `done` and `PC_inc` outside EXEC.
  - `run` deasserting in FETCH or EXEC; the current instruction completes and the block stops at CLEAR.
- `rst` mid-fetch or mid-EXEC returns all state to reset values on the next edge. IR=0 also drives the execution FSMs to idle.

## Structure
- Shared package `mcu_pkg` holds:
  - opcode constants OP_NOP=4'h0, OP_ALUI_A=4'h1, OP_ALUI_B=4'h2, OP_HALT=4'hF;
  - the state enum `disp_state_t`;
  - default `EXEC_MASK`.
- Sub-module `exec_watchdog` (clear, enable, terminal-count output, parameter `TIMEOUT`) holds the EXEC timeout counter.
- Everything else (FSM, PC, IR) lives in `instr_dispatch`.

## Test plan
- Reset, `run`=1, memory[0]=16'h1085 (ALUI), model pulses `PC_inc` at IR+1 and `done` at IR+8 → IR=16'h1085 for 9 cycles, then 0 for 1 cycle, PC=1, next fetch at `mem_addr`=1, `fault`=0.
- memory[0..2]=16'h0000, 16'h0000, 16'hF000 → PC 0→1→2, halts with PC=2, `halted`=1, `busy`=0, `mem_rd` never reasserts.
- Fetch 16'h5000 with `EXEC_MASK`=16'h0006 → `fault`=1, HALT, `fullBitNum`=0, PC unchanged.
- ALUI issued, `done` never pulses → `fault`=1 exactly 15 EXEC cycles after IR load, IR=0. Repeat with `done` on cycle 15 → no fault.
- PC_W=8, PC=8'hFF, NOP fetched → PC=8'h00, next `mem_addr`=0.
- `rst` pulsed during EXEC (IR=16'h2041) → next cycle all outputs at reset values, state IDLE. Deassert `run` during EXEC → block finishes the instruction and parks in IDLE after CLEAR.
